// File: rtl/alu_md_ctrl.sv
// alu_md_ctrl: execute-stage ALU control decode, RV32I ALU / branch compare and an
// iterative RV32M shift-add multiplier / restoring divider behind valid/ready handshakes.
// in_ready is low from accept until the result has been consumed, stalling the core.
module alu_md_ctrl #(
  parameter int unsigned XLEN   = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      aluOp,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch,
  output logic            illegal
);

  localparam int unsigned    ShW      = $clog2(XLEN);
  localparam logic [ShW-1:0] LastIter = ShW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;
  localparam logic [6:0] F7MExt = 7'b0000001;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  // Architectural state
  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            branch_q, branch_d;
  logic            illegal_q, illegal_d;

  // Iterative engine state, shared by multiply and divide
  logic [ShW-1:0]  cnt_q, cnt_d;
  logic [XLEN:0]   acc_q, acc_d;    // partial product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;      // multiplier -> product low half / dividend -> quotient
  logic [XLEN-1:0] opnd_q, opnd_d;  // multiplicand / divisor magnitude
  logic            neg_q, neg_d;    // negate product or quotient at the end
  logic            rneg_q, rneg_d;  // negate remainder at the end
  logic            hi_q, hi_d;      // mul: return high half; div: return remainder

  // Shared single-cycle datapath
  logic [ShW-1:0]  sh;
  logic [XLEN-1:0] sum, diff, sra_res, alu_res;
  logic            lt_s, lt_u, alu_alt;

  // Decode results
  logic [XLEN-1:0] dec_res;
  logic            dec_br, dec_ill;
  logic            mul_req, div_req, div_fast;

  // Operand conditioning for M extension
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            b_zero, div_ovf;

  // Iteration step and final results
  logic [XLEN:0]     mul_sum, mul_acc;
  logic [XLEN-1:0]   mul_lo;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN:0]     div_shift, div_trial, div_acc;
  logic              div_bit;
  logic [XLEN-1:0]   div_lo, quo, rem, div_res;

  assign sh      = b[ShW-1:0];
  assign sum     = a + b;
  assign diff    = a - b;
  assign sra_res = $signed(a) >>> sh;
  assign lt_s    = $signed(a) < $signed(b);
  assign lt_u    = a < b;

  // sub for R-type funct3=000, sra for either type at funct3=101
  assign alu_alt = (funct7 == F7Alt) && ((aluOp == 2'b10) || (funct3 == 3'b101));

  // Base integer operation selected by funct3
  always_comb begin
    alu_res = '0;
    case (funct3)
      3'b000:  alu_res = alu_alt ? diff : sum;
      3'b001:  alu_res = a << sh;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, lt_u};
      3'b100:  alu_res = a ^ b;
      3'b101:  alu_res = alu_alt ? sra_res : (a >> sh);
      3'b110:  alu_res = a | b;
      3'b111:  alu_res = a & b;
      default: alu_res = '0;
    endcase
  end

  // Operand signedness: mulh/mulhsu sign-extend a, mulh also b; div/rem are signed
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    if (funct3[2]) begin
      a_sgn = ~funct3[0];
      b_sgn = ~funct3[0];
    end else begin
      a_sgn = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
      b_sgn = (funct3[1:0] == 2'b01);
    end
  end

  assign a_neg    = a_sgn & a[XLEN-1];
  assign b_neg    = b_sgn & b[XLEN-1];
  assign mag_a    = a_neg ? -a : a;
  assign mag_b    = b_neg ? -b : b;
  assign b_zero   = (b == '0);
  assign div_ovf  = a_sgn && (a == MinNeg) && (b == '1);
  assign div_fast = div_req && (b_zero || div_ovf);

  // Control decode: single-cycle result, branch, illegal, or hand-off to the M engine
  always_comb begin
    dec_res = '0;
    dec_br  = 1'b0;
    dec_ill = 1'b0;
    mul_req = 1'b0;
    div_req = 1'b0;
    case (aluOp)
      2'b00: dec_res = sum;
      2'b01: begin
        case (funct3)
          3'b000:  dec_br = (a == b);
          3'b001:  dec_br = (a != b);
          3'b100:  dec_br = lt_s;
          3'b101:  dec_br = ~lt_s;
          3'b110:  dec_br = lt_u;
          3'b111:  dec_br = ~lt_u;
          default: dec_ill = 1'b1;
        endcase
        dec_res = dec_ill ? '0 : diff;
      end
      2'b10: begin
        if (funct7 == F7Base) begin
          dec_res = alu_res;
        end else if ((funct7 == F7Alt) && ((funct3 == 3'b000) || (funct3 == 3'b101))) begin
          dec_res = alu_res;
        end else if ((funct7 == F7MExt) && MUL_EN) begin
          if (funct3[2]) begin
            div_req = 1'b1;
            // Divide by zero and signed overflow complete without iterating
            if (b_zero) begin
              dec_res = funct3[1] ? a : '1;
            end else if (div_ovf) begin
              dec_res = funct3[1] ? '0 : a;
            end
          end else begin
            mul_req = 1'b1;
          end
        end else begin
          dec_ill = 1'b1;
        end
      end
      default: begin
        if ((funct3 == 3'b001) && (funct7 != F7Base)) begin
          dec_ill = 1'b1;
        end else if ((funct3 == 3'b101) && (funct7 != F7Base) && (funct7 != F7Alt)) begin
          dec_ill = 1'b1;
        end else begin
          dec_res = alu_res;
        end
      end
    endcase
  end

  // One shift-add multiply step: add multiplicand on multiplier LSB, shift pair right
  always_comb begin
    mul_sum = acc_q + {1'b0, opnd_q & {XLEN{lo_q[0]}}};
    mul_acc = {1'b0, mul_sum[XLEN:1]};
    mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
    prod    = {mul_acc[XLEN-1:0], mul_lo};
    prod_s  = neg_q ? -prod : prod;
    mul_res = hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
  end

  // One restoring divide step: shift in next dividend bit, subtract if it fits
  always_comb begin
    div_shift = {acc_q[XLEN-1:0], lo_q[XLEN-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    div_bit   = ~div_trial[XLEN];
    div_acc   = div_bit ? div_trial : div_shift;
    div_lo    = {lo_q[XLEN-2:0], div_bit};
    quo       = div_lo;
    rem       = div_acc[XLEN-1:0];
    div_res   = hi_q ? (rneg_q ? -rem : rem) : (neg_q ? -quo : quo);
  end

  // Next state: accept in idle, iterate in MUL/DIV, hold result until consumed
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    branch_d  = branch_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    hi_d      = hi_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          result_d  = dec_res;
          branch_d  = dec_br;
          illegal_d = dec_ill;
          cnt_d     = '0;
          if (mul_req) begin
            state_d  = StMul;
            result_d = '0;
            acc_d    = '0;
            lo_d     = mag_b;
            opnd_d   = mag_a;
            neg_d    = a_neg ^ b_neg;
            rneg_d   = 1'b0;
            hi_d     = (funct3[1:0] != 2'b00);
          end else if (div_req && !div_fast) begin
            state_d  = StDiv;
            result_d = '0;
            acc_d    = '0;
            lo_d     = mag_a;
            opnd_d   = mag_b;
            neg_d    = a_neg ^ b_neg;
            rneg_d   = a_neg;
            hi_d     = funct3[1];
          end else begin
            state_d = StDone;
          end
        end
      end
      StMul: begin
        acc_d = mul_acc;
        lo_d  = mul_lo;
        cnt_d = cnt_q + ShW'(1);
        if (cnt_q == LastIter) begin
          state_d  = StDone;
          result_d = mul_res;
        end
      end
      StDiv: begin
        acc_d = div_acc;
        lo_d  = div_lo;
        cnt_d = cnt_q + ShW'(1);
        if (cnt_q == LastIter) begin
          state_d  = StDone;
          result_d = div_res;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      result_q  <= '0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      hi_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      branch_q  <= branch_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      hi_q      <= hi_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign branch    = branch_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_md_ctrl.sv
// Randomised bench for alu_md_ctrl against a plain-arithmetic reference model.
module tb_alu_md_ctrl;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready, out_valid, out_ready;
  logic [1:0]      aluOp;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] a, b, result;
  logic            branch, illegal;

  logic            z_in_valid, z_in_ready, z_out_valid, z_out_ready;
  logic [XLEN-1:0] z_result;
  logic            z_branch, z_illegal;

  always #5 clk = ~clk;

  alu_md_ctrl #(.XLEN(XLEN), .MUL_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .aluOp(aluOp), .funct3(funct3), .funct7(funct7), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .branch(branch), .illegal(illegal)
  );

  alu_md_ctrl #(.XLEN(XLEN), .MUL_EN(1'b0)) u_dut_nom (
    .clk(clk), .rst_n(rst_n), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .aluOp(aluOp), .funct3(funct3), .funct7(funct7), .a(a), .b(b),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .result(z_result),
    .branch(z_branch), .illegal(z_illegal)
  );

  typedef struct {
    logic [31:0] res;
    logic        br;
    logic        ill;
    int          lat;
  } exp_t;

  int unsigned errors = 0;
  int unsigned checks = 0;
  exp_t        exp_q[$];
  int          cyc = 0;
  bit          seen = 1'b0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, got, want);
    end
  endtask

  function automatic logic [31:0] base_op(input logic [2:0] f3, input bit alt,
                                          input logic [31:0] x, input logic [31:0] y);
    int sx = x;
    int sy = y;
    int sr;
    case (f3)
      3'd0: return alt ? x - y : x + y;
      3'd1: return x << y[4:0];
      3'd2: return (sx < sy) ? 32'd1 : 32'd0;
      3'd3: return (x < y) ? 32'd1 : 32'd0;
      3'd4: return x ^ y;
      3'd5: begin
        if (alt) begin
          sr = sx >>> y[4:0];
          return sr;
        end
        return x >> y[4:0];
      end
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic exp_t model(input bit mul_en, input logic [1:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] x,
                                 input logic [31:0] y);
    exp_t        e;
    int          sx = x;
    int          sy = y;
    longint      lx, ly;
    logic [63:0] p;
    logic [31:0] q, r;
    bit          sgn;
    e.res = '0; e.br = 1'b0; e.ill = 1'b0; e.lat = 1;
    case (op)
      2'd0: e.res = x + y;
      2'd1: begin
        case (f3)
          3'd0: e.br = (x == y);
          3'd1: e.br = (x != y);
          3'd4: e.br = (sx < sy);
          3'd5: e.br = (sx >= sy);
          3'd6: e.br = (x < y);
          3'd7: e.br = (x >= y);
          default: e.ill = 1'b1;
        endcase
        e.res = e.ill ? 32'd0 : x - y;
      end
      2'd2: begin
        if (f7 == 7'h00) e.res = base_op(f3, 1'b0, x, y);
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) e.res = base_op(f3, 1'b1, x, y);
        else if (f7 == 7'h01 && mul_en) begin
          if (!f3[2]) begin
            e.lat = 33;
            lx = longint'(sx);
            case (f3)
              3'd0: begin p = {32'b0, x} * {32'b0, y}; e.res = p[31:0]; end
              3'd1: begin ly = longint'(sy); p = lx * ly; e.res = p[63:32]; end
              3'd2: begin ly = longint'({32'b0, y}); p = lx * ly; e.res = p[63:32]; end
              default: begin p = {32'b0, x} * {32'b0, y}; e.res = p[63:32]; end
            endcase
          end else begin
            sgn = !f3[0];
            if (y == 0) begin
              q = '1; r = x;
            end else if (sgn && x == 32'h8000_0000 && y == 32'hffff_ffff) begin
              q = x; r = 0;
            end else begin
              e.lat = 33;
              if (sgn) begin q = sx / sy; r = sx % sy; end
              else begin q = x / y; r = x % y; end
            end
            e.res = f3[1] ? r : q;
          end
        end else e.ill = 1'b1;
      end
      default: begin
        if ((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20))
          e.ill = 1'b1;
        else e.res = base_op(f3, (f3 == 3'd5) && (f7 == 7'h20), x, y);
      end
    endcase
    return e;
  endfunction

  task automatic pin(input string name, input exp_t e, input logic [31:0] res,
                     input logic br, input logic ill, input int lat);
    chk({name, "_res"}, 64'(e.res), 64'(res));
    chk({name, "_br"}, 64'(e.br), 64'(br));
    chk({name, "_ill"}, 64'(e.ill), 64'(ill));
    chk({name, "_lat"}, 64'(e.lat), 64'(lat));
  endtask

  // Compare process: every cycle after reset, check DUT outputs against the expectation queue
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (exp_q.size() == 0) begin
        chk("idle_in_ready", 64'(in_ready), 64'(1));
        chk("idle_out_valid", 64'(out_valid), 64'(0));
      end else begin
        cyc++;
        if (out_valid) begin
          if (!seen) chk("latency", 64'(cyc), 64'(exp_q[0].lat));
          seen = 1'b1;
          chk("result", 64'(result), 64'(exp_q[0].res));
          chk("branch", 64'(branch), 64'(exp_q[0].br));
          chk("illegal", 64'(illegal), 64'(exp_q[0].ill));
          chk("done_in_ready", 64'(in_ready), 64'(0));
          if (out_ready) begin
            void'(exp_q.pop_front());
            seen = 1'b0;
          end
        end else begin
          chk("busy_in_ready", 64'(in_ready), 64'(0));
        end
      end
    end
  end

  // Entry and exit: 1 time unit after a rising edge, DUT idle
  task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] x, input logic [31:0] y, input int hold);
    exp_t e;
    bit   got;
    e = model(1'b1, op, f3, f7, x, y);
    in_valid = 1'b1; aluOp = op; funct3 = f3; funct7 = f7; a = x; b = y;
    @(posedge clk);
    exp_q.push_back(e);
    cyc = 0;
    seen = 1'b0;
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; funct3 = 3'($urandom); funct7 = 7'($urandom);
    aluOp = 2'($urandom);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout: out_valid=0 after 40 cycles, required 1");
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      return;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      a = $urandom;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic run_nom(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e = model(1'b0, op, f3, f7, x, y);
    z_in_valid = 1'b1; aluOp = op; funct3 = f3; funct7 = f7; a = x; b = y;
    @(posedge clk);
    #1;
    z_in_valid = 1'b0;
    @(negedge clk);
    chk("nom_out_valid", 64'(z_out_valid), 64'(1));
    chk("nom_result", 64'(z_result), 64'(e.res));
    chk("nom_illegal", 64'(z_illegal), 64'(e.ill));
    chk("nom_branch", 64'(z_branch), 64'(e.br));
    @(posedge clk);
    #1;
    z_out_ready = 1'b1;
    @(posedge clk);
    #1;
    z_out_ready = 1'b0;
    @(negedge clk);
    chk("nom_in_ready", 64'(z_in_ready), 64'(1));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hffff_ffff;
      3: return 32'h8000_0000;
      4: return 32'h7fff_ffff;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [6:0] f7;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; aluOp = '0; funct3 = '0; funct7 = '0;
    a = '0; b = '0; z_in_valid = 1'b0; z_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_branch", 64'(branch), 64'(0));
    chk("rst_illegal", 64'(illegal), 64'(0));
    chk("rst_nom_out_valid", 64'(z_out_valid), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Hand-computed values pinning the model
    pin("sub", model(1, 2'b10, 3'b000, 7'h20, 32'd5, 32'd7), 32'hffff_fffe, 0, 0, 1);
    pin("blt", model(1, 2'b01, 3'b100, 7'h00, 32'hffff_ffff, 32'd1), 32'hffff_fffe, 1, 0, 1);
    pin("bltu", model(1, 2'b01, 3'b110, 7'h00, 32'hffff_ffff, 32'd1), 32'hffff_fffe, 0, 0, 1);
    pin("bill", model(1, 2'b01, 3'b010, 7'h00, 32'hffff_ffff, 32'd1), 32'h0, 0, 1, 1);
    pin("mul", model(1, 2'b10, 3'b000, 7'h01, 32'hffff_ffff, 32'd3), 32'hffff_fffd, 0, 0, 33);
    pin("mulh", model(1, 2'b10, 3'b001, 7'h01, 32'hffff_ffff, 32'd3), 32'hffff_ffff, 0, 0, 33);
    pin("mulhu", model(1, 2'b10, 3'b011, 7'h01, 32'hffff_ffff, 32'd3), 32'h2, 0, 0, 33);
    pin("divu", model(1, 2'b10, 3'b101, 7'h01, 32'd100, 32'd7), 32'd14, 0, 0, 33);
    pin("remu", model(1, 2'b10, 3'b111, 7'h01, 32'd100, 32'd7), 32'd2, 0, 0, 33);
    pin("dovf", model(1, 2'b10, 3'b100, 7'h01, 32'h8000_0000, 32'hffff_ffff),
        32'h8000_0000, 0, 0, 1);
    pin("rovf", model(1, 2'b10, 3'b110, 7'h01, 32'h8000_0000, 32'hffff_ffff), 32'h0, 0, 0, 1);
    pin("divu0", model(1, 2'b10, 3'b101, 7'h01, 32'd55, 32'd0), 32'hffff_ffff, 0, 0, 1);
    pin("remu0", model(1, 2'b10, 3'b111, 7'h01, 32'd55, 32'd0), 32'd55, 0, 0, 1);
    pin("add", model(1, 2'b00, 3'b000, 7'h00, 32'd2, 32'd3), 32'd5, 0, 0, 1);
    pin("nom_mul", model(0, 2'b10, 3'b000, 7'h01, 32'd6, 32'd7), 32'h0, 0, 1, 1);

    // Directed transactions
    run_op(2'b10, 3'b000, 7'h20, 32'd5, 32'd7, 0);
    run_op(2'b01, 3'b100, 7'h00, 32'hffff_ffff, 32'd1, 0);
    run_op(2'b01, 3'b110, 7'h00, 32'hffff_ffff, 32'd1, 0);
    run_op(2'b01, 3'b010, 7'h00, 32'hffff_ffff, 32'd1, 5);
    run_op(2'b10, 3'b000, 7'h01, 32'hffff_ffff, 32'd3, 0);
    run_op(2'b10, 3'b001, 7'h01, 32'hffff_ffff, 32'd3, 0);
    run_op(2'b10, 3'b011, 7'h01, 32'hffff_ffff, 32'd3, 5);
    run_op(2'b10, 3'b101, 7'h01, 32'd100, 32'd7, 0);
    run_op(2'b10, 3'b111, 7'h01, 32'd100, 32'd7, 0);
    run_op(2'b10, 3'b100, 7'h01, 32'h8000_0000, 32'hffff_ffff, 0);
    run_op(2'b10, 3'b110, 7'h01, 32'h8000_0000, 32'hffff_ffff, 0);
    run_op(2'b10, 3'b101, 7'h01, 32'd55, 32'd0, 0);
    run_op(2'b10, 3'b111, 7'h01, 32'd55, 32'd0, 0);
    run_op(2'b11, 3'b101, 7'h20, 32'h8000_0010, 32'd4, 0);
    run_op(2'b11, 3'b001, 7'h20, 32'd1, 32'd4, 0);

    // Randomised transactions
    for (int n = 0; n < 160; n++) begin
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      run_op(2'($urandom), 3'($urandom), f7, pick(), pick(), $urandom_range(0, 2));
    end

    // Reset during a divide abandons it
    in_valid = 1'b1; aluOp = 2'b10; funct3 = 3'b101; funct7 = 7'h01; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    exp_q.push_back(model(1, 2'b10, 3'b101, 7'h01, 32'd1000, 32'd3));
    cyc = 0;
    seen = 1'b0;
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    seen = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_result", 64'(result), 64'(0));
    repeat (40) @(posedge clk);
    #1;
    run_op(2'b00, 3'b000, 7'h00, 32'd2, 32'd3, 0);

    // Build without the M extension
    run_nom(2'b10, 3'b000, 7'h01, 32'd6, 32'd7);
    run_nom(2'b10, 3'b100, 7'h01, 32'd60, 32'd7);
    run_nom(2'b10, 3'b000, 7'h00, 32'd6, 32'd7);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
